// File: rtl/spi_slave_responder.sv
// SPI mode-0 target (CPOL=0, CPHA=0, MSB first), oversampled in the clk domain.
// Exposes received words and accepts words to send as valid/ready byte streams.
module spi_slave_responder #(
  parameter int unsigned   DW          = 8,
  parameter int unsigned   SYNC_STAGES = 2,
  parameter logic [DW-1:0] IDLE_WORD   = DW'(8'hFF)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          spi_cs,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic          clr_flags,
  output logic          rx_overflow,
  output logic          tx_underrun,
  output logic          busy
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_RELOAD
  } state_e;

  // Pin synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, sclk_rise, sclk_fall;

  // Frame state
  state_e          state_q, state_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic [DW-1:0]   tx_shift_q, tx_shift_d;
  logic [DW-1:0]   rx_shift_q, rx_shift_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_ready_q, tx_ready_d;
  logic            rx_overflow_q, rx_overflow_d;
  logic            tx_underrun_q, tx_underrun_d;

  // Per-cycle events decoded by the FSM
  logic            handshake;
  logic            word_done;
  logic            ovf_set;
  logic            udr_set;
  logic [DW-1:0]   rx_word;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // cs_prev_q resets low, so a CS held low through reset is not taken as a fall;
  // CS has to be seen high before the next frame can start.
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign rx_word = {rx_shift_q[DW-2:0], mosi_s};

  // NOTE: sequential state is only ever updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      bitcnt_q      <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_ready_d = 1'b0;
    handshake  = 1'b0;
    word_done  = 1'b0;
    udr_set    = 1'b0;

    if (state_q != S_IDLE && cs_s) begin
      // Abort: the partial rx word is dropped and any consumed tx word is lost.
      state_d    = S_IDLE;
      bitcnt_d   = '0;
      rx_shift_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) state_d = S_LOAD;
        end
        S_LOAD: begin
          handshake = 1'b1;
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_d = rx_word;
            if (bitcnt_q == CW'(DW - 1)) begin
              bitcnt_d  = '0;
              word_done = 1'b1;
              state_d   = S_RELOAD;
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end else if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
          end
        end
        S_RELOAD: begin
          if (sclk_fall) handshake = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase

      if (handshake) begin
        state_d  = S_SHIFT;
        bitcnt_d = '0;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_ready_d = 1'b1;
        end else begin
          tx_shift_d = IDLE_WORD;
          udr_set    = 1'b1;
        end
      end
    end
  end

  // Receive handoff: a completing word may replace one being accepted this cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovf_set    = 1'b0;
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Setting a flag wins over clearing it in the same cycle.
  assign rx_overflow_d = ovf_set | (rx_overflow_q & ~clr_flags);
  assign tx_underrun_d = udr_set | (tx_underrun_q & ~clr_flags);

  // tx_ready is a registered pulse, one cycle after tx_data was captured, so it
  // carries no combinational path from tx_valid.
  assign tx_ready    = tx_ready_q;
  assign spi_miso_oe = (state_q != S_IDLE);
  assign spi_miso    = spi_miso_oe & tx_shift_q[DW-1];
  assign busy        = (state_q != S_IDLE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overflow = rx_overflow_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a bit-banged mode-0 master, a tx queue
// producer and an rx logger, with hand-computed expected bytes.
module tb_spi_slave_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       spi_cs, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       clr_flags;
  logic       rx_overflow, tx_underrun, busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         tx_pulses = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_got[$];
  logic       rise_rx_valid;

  spi_slave_responder #(.DW(8), .SYNC_STAGES(SYNC), .IDLE_WORD(8'hFF)) dut (
    .clk(clk), .rstn(rstn),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .clr_flags(clr_flags), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Producer pops on each tx_ready pulse; logger records each accepted rx word.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (tx_ready) begin
        tx_pulses++;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      tx_valid = (tx_q.size() > 0);
      tx_data  = tx_valid ? tx_q[0] : 8'h00;
    end
  end

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before each rising edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      rise_rx_valid = rx_valid;
      repeat (HALF - SYNC - 2) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] exp_tx[3];
    logic [7:0] exp_rx[3];
    int         p0, n0;

    rstn = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    rx_ready = 1'b0; clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {17'd0, spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
                            rx_overflow, tx_underrun, busy}, 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single word, A5 out / 3C in, rx_valid latency after the 8th rise
    tx_q.push_back(8'hA5);
    repeat (2) @(negedge clk);
    p0 = tx_pulses;
    cs_low();
    spi_bits(8'h3C, 8, mi);
    check("t1_rx_valid_latency", {31'd0, rise_rx_valid}, 32'h1);
    check("t1_rx_data", {24'd0, rx_data}, 32'h3C);
    cs_high();
    check("t1_miso", {24'd0, mi}, 32'hA5);
    check("t1_tx_pulses", tx_pulses - p0, 32'd1);

    // 2: three back-to-back words in one frame
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_got.delete();
    exp_tx = '{8'h01, 8'h02, 8'h03};
    exp_rx = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) tx_q.push_back(exp_tx[i]);
    repeat (2) @(negedge clk);
    p0 = tx_pulses;
    cs_low();
    for (int i = 0; i < 3; i++) begin
      spi_bits(exp_rx[i], 8, mi);
      check($sformatf("t2_miso%0d", i), {24'd0, mi}, {24'd0, exp_tx[i]});
    end
    cs_high();
    check("t2_rx_count", rx_got.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_rx%0d", i), {24'd0, (rx_got.size() > i) ? rx_got[i] : 8'h00},
            {24'd0, exp_rx[i]});
    check("t2_tx_pulses", tx_pulses - p0, 32'd3);

    // 3: underrun sends IDLE_WORD, flag cleared by clr_flags
    pulse_clr();
    cs_low();
    spi_bits(8'h00, 8, mi);
    cs_high();
    check("t3_miso_idle", {24'd0, mi}, 32'hFF);
    check("t3_underrun_set", {31'd0, tx_underrun}, 32'h1);
    pulse_clr();
    check("t3_underrun_clr", {31'd0, tx_underrun}, 32'h0);

    // 4: overflow while rx_ready is low
    rx_ready = 1'b0;
    pulse_clr();
    cs_low();
    spi_bits(8'h5A, 8, mi);
    check("t4_rx_first", {24'd0, rx_data}, 32'h5A);
    spi_bits(8'hC3, 8, mi);
    cs_high();
    check("t4_rx_kept", {24'd0, rx_data}, 32'h5A);
    check("t4_rx_valid_held", {31'd0, rx_valid}, 32'h1);
    check("t4_overflow", {31'd0, rx_overflow}, 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("t4_rx_valid_drop", {31'd0, rx_valid}, 32'h0);

    // 5: abort after 5 bits, then a clean frame
    pulse_clr();
    n0 = rx_got.size();
    cs_low();
    spi_bits(8'h96, 5, mi);
    spi_cs = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("t5_oe_off", {31'd0, spi_miso_oe}, 32'h0);
    check("t5_busy_off", {31'd0, busy}, 32'h0);
    repeat (8) @(negedge clk);
    check("t5_no_rx", rx_got.size(), n0);
    tx_q.push_back(8'h81);
    repeat (2) @(negedge clk);
    cs_low();
    spi_bits(8'h81, 8, mi);
    cs_high();
    check("t5_miso", {24'd0, mi}, 32'h81);
    check("t5_rx_data", {24'd0, rx_data}, 32'h81);
    check("t5_rx_count", rx_got.size(), n0 + 1);

    // 6: reset mid-word; CS must be seen high before the next frame
    cs_low();
    spi_bits(8'hF0, 3, mi);
    rstn = 1'b0;
    #1;
    check("t6_reset_outputs", {17'd0, spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
                               rx_overflow, tx_underrun, busy}, 32'h0);
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_wait_cs_high", {30'd0, busy, spi_miso_oe}, 32'h0);
    tx_q.push_back(8'h42);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    cs_low();
    spi_bits(8'h7E, 8, mi);
    cs_high();
    check("t6_miso", {24'd0, mi}, 32'h42);
    check("t6_rx_data", {24'd0, rx_data}, 32'h7E);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
